// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronises RXD, samples at 16x oversampling and emits one
// character with framing, parity and break status per received frame.
module uart_rx_deframer #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       enable16,
  input  logic       RXD,
  input  logic [1:0] lcr_wls,
  input  logic       lcr_pen,
  input  logic       lcr_eps,
  input  logic       lcr_sp,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_fe,
  output logic       rx_pe,
  output logic       rx_bi,
  output logic       rx_busy
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_p_q;
  logic                   rxd_s;
  logic                   fall;

  state_e     state_q;
  logic [3:0] cnt_q;
  logic [2:0] bit_q;
  logic [7:0] shift_q;
  logic       par_q;
  logic [1:0] wls_q;
  logic       pen_q, eps_q, sp_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q, rx_fe_q, rx_pe_q, rx_bi_q;

  logic mid_bit, full_bit, last_bit, par_exp, brk;

  assign rxd_s    = sync_q[SYNC_STAGES-1];
  assign fall     = rxd_p_q & ~rxd_s;
  assign mid_bit  = enable16 && (cnt_q == 4'd7);
  assign full_bit = enable16 && (cnt_q == 4'd15);
  assign last_bit = (bit_q == (3'd4 + {1'b0, wls_q}));
  assign par_exp  = sp_q ? ~eps_q : (^shift_q ^ ~eps_q);
  // Break: every sampled bit of the frame (data, parity, stop) was low.
  assign brk      = (shift_q == 8'h00) && (!pen_q || !par_q) && !rxd_s;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sync_q  <= '1;
      rxd_p_q <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], RXD};
      rxd_p_q <= rxd_s;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      bit_q      <= 3'd0;
      shift_q    <= 8'h00;
      par_q      <= 1'b0;
      wls_q      <= 2'd0;
      pen_q      <= 1'b0;
      eps_q      <= 1'b0;
      sp_q       <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_fe_q    <= 1'b0;
      rx_pe_q    <= 1'b0;
      rx_bi_q    <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (enable16 && (state_q != StIdle)) cnt_q <= cnt_q + 4'd1;
      case (state_q)
        StIdle: begin
          if (fall) begin
            wls_q   <= lcr_wls;
            pen_q   <= lcr_pen;
            eps_q   <= lcr_eps;
            sp_q    <= lcr_sp;
            cnt_q   <= 4'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            par_q   <= 1'b0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (mid_bit) begin
            if (rxd_s) begin
              state_q <= StIdle;
            end else begin
              cnt_q   <= 4'd0;
              state_q <= StData;
            end
          end
        end
        StData: begin
          // Counter wraps 15->0 by itself, so each later sample lands 16 ticks on.
          if (full_bit) begin
            shift_q[bit_q] <= rxd_s;
            bit_q          <= bit_q + 3'd1;
            if (last_bit) state_q <= pen_q ? StParity : StStop;
          end
        end
        StParity: begin
          if (full_bit) begin
            par_q   <= rxd_s;
            state_q <= StStop;
          end
        end
        StStop: begin
          if (full_bit) begin
            state_q    <= StIdle;
            rx_valid_q <= 1'b1;
            rx_fe_q    <= ~rxd_s | brk;
            rx_pe_q    <= pen_q & (par_q != par_exp);
            rx_bi_q    <= brk;
            rx_data_q  <= brk ? 8'h00 : shift_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_fe    = rx_fe_q;
  assign rx_pe    = rx_pe_q;
  assign rx_bi    = rx_bi_q;
  assign rx_busy  = (state_q != StIdle);

endmodule
